// File: rtl/key_choice_queue.sv
// Key matcher with latched choice, hold timing and a show-ahead event FIFO; choose/push land 1 cycle after the strobe.
// Backpressure: evt_ready pops the head; a push into a full FIFO without a pop is dropped and flags overflow.
module key_choice_queue #(
   parameter int                  N_KEYS      = 4,
   parameter logic [9*N_KEYS-1:0] KEY_CODES   = {9'h074, 9'h06B, 9'h072, 9'h069},
   parameter int                  DEPTH       = 4,
   parameter int                  HOLD_CYCLES = 50_000_000,
   localparam int                 IW          = $clog2(N_KEYS + 1),
   localparam int                 CW          = $clog2(HOLD_CYCLES + 1),
   localparam int                 AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_valid,
   input  logic [8:0]    key_code,
   input  logic          key_pressed,
   output logic [IW-1:0] choose,
   output logic          evt_valid,
   input  logic          evt_ready,
   output logic [IW-1:0] evt_index,
   output logic          evt_long,
   output logic          overflow,
   input  logic          clr_overflow
);

   logic [IW-1:0] w_match_idx;
   logic          w_match;
   logic          w_make;
   logic          w_same;
   logic          w_break;
   logic          w_push_long;

   logic [IW-1:0] r_choose;
   logic          r_active;
   logic [IW-1:0] r_trk_idx;
   logic [8:0]    r_trk_code;
   logic [CW-1:0] r_cnt;

   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [IW:0]   r_mem [DEPTH];
   logic          r_overflow;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_wr;
   logic          w_drop;

   // Scan high to low so the lowest duplicated entry ends up winning.
   always_comb begin
      w_match     = 1'b0;
      w_match_idx = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (key_code == KEY_CODES[9*i +: 9]) begin
            w_match     = 1'b1;
            w_match_idx = IW'(i);
         end
      end
   end

   assign w_make      = key_valid & key_pressed & w_match;
   assign w_same      = r_active & (w_match_idx == r_trk_idx);
   assign w_break     = key_valid & ~key_pressed & r_active & (key_code == r_trk_code);
   assign w_push_long = (r_cnt == CW'(HOLD_CYCLES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_choose   <= '0;
         r_active   <= 1'b0;
         r_trk_idx  <= '0;
         r_trk_code <= '0;
         r_cnt      <= '0;
      end else if (w_make && !w_same) begin
         r_choose   <= w_match_idx + IW'(1);
         r_active   <= 1'b1;
         r_trk_idx  <= w_match_idx;
         r_trk_code <= key_code;
         r_cnt      <= '0;
      end else if (w_break) begin
         r_active   <= 1'b0;
         r_cnt      <= '0;
      end else if (r_active && !w_push_long) begin
         r_cnt      <= r_cnt + CW'(1);
      end
   end

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = ~w_empty & evt_ready;
   // A pop frees the head slot at the same edge, so a full FIFO can still accept.
   assign w_wr    = w_break & (~w_full | w_pop);
   assign w_drop  = w_break & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {r_trk_idx + IW'(1), w_push_long};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign choose                = r_choose;
   assign overflow              = r_overflow;
   assign evt_valid             = ~w_empty;
   assign {evt_index, evt_long} = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_key_choice_queue.sv
// Randomized and directed bench for key_choice_queue with an event scoreboard and a cycle-level press model.
module tb_key_choice_queue;
   localparam int NK   = 4;
   localparam int DEP  = 4;
   localparam int HOLD = 8;
   localparam int IW   = 3;
   localparam logic [35:0] CODES = {9'h074, 9'h06B, 9'h072, 9'h069};

   typedef struct {
      int idx;
      int lng;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          key_valid = 1'b0;
   logic [8:0]    key_code = '0;
   logic          key_pressed = 1'b0;
   logic          evt_ready = 1'b0;
   logic          clr_overflow = 1'b0;
   logic [IW-1:0] choose;
   logic          evt_valid;
   logic [IW-1:0] evt_index;
   logic          evt_long;
   logic          overflow;

   key_choice_queue #(
      .N_KEYS(NK), .KEY_CODES(CODES), .DEPTH(DEP), .HOLD_CYCLES(HOLD)
   ) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .key_pressed(key_pressed), .choose(choose), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_index(evt_index), .evt_long(evt_long),
      .overflow(overflow), .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;

   logic [8:0] keytab [4] = '{9'h069, 9'h072, 9'h06B, 9'h074};
   int  mdl_choose = 0;
   int  mdl_cnt    = 0;
   int  mdl_active = 0;
   int  mdl_key    = 0;
   int  mdl_p      = 0;
   int  mdl_ovf    = 0;
   int  cyc_n      = 0;
   ev_t scb [$];
   int  n_vec = 0;
   int  n_err = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic int lookup(input logic [8:0] c);
      for (int i = 0; i < NK; i++) begin
         if (c == keytab[i]) return i;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      mdl_choose = 0;
      mdl_cnt    = 0;
      mdl_active = 0;
      mdl_key    = 0;
      mdl_ovf    = 0;
      scb.delete();
   endfunction

   // Press-level model: holds are measured from the make cycle number, not a counter.
   function automatic void model_step(input bit kv, input logic [8:0] kc, input bit kp,
                                      input bit rdy, input bit clr);
      int  m;
      bit  pop;
      bit  push;
      bit  acc;
      ev_t e;
      m    = lookup(kc);
      pop  = rdy && (mdl_cnt > 0);
      push = 1'b0;
      acc  = 1'b0;
      e.idx = 0;
      e.lng = 0;
      if (kv && kp && m >= 0) begin
         if (!(mdl_active != 0 && mdl_key == m)) begin
            mdl_choose = m + 1;
            mdl_active = 1;
            mdl_key    = m;
            mdl_p      = cyc_n;
         end
      end else if (kv && !kp && mdl_active != 0 && kc == keytab[mdl_key]) begin
         push       = 1'b1;
         e.idx      = mdl_key + 1;
         e.lng      = (cyc_n - mdl_p - 1 >= HOLD) ? 1 : 0;
         mdl_active = 0;
      end
      if (push && mdl_cnt == DEP && !pop) mdl_ovf = 1;
      else if (clr) mdl_ovf = 0;
      if (push && (mdl_cnt < DEP || pop)) begin
         acc = 1'b1;
         scb.push_back(e);
      end
      mdl_cnt = mdl_cnt - int'(pop) + int'(acc);
   endfunction

   task automatic cyc(input bit kv, input logic [8:0] kc, input bit kp,
                      input bit rdy, input bit clr);
      key_valid    = kv;
      key_code     = kc;
      key_pressed  = kp;
      evt_ready    = rdy;
      clr_overflow = clr;
      @(posedge clk);
      if (rst) model_step(kv, kc, kp, rdy, clr);
      #1;
      cyc_n++;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int k = 0; k < n; k++) cyc(1'b0, 9'h000, 1'b0, rdy, 1'b0);
   endtask

   task automatic rand_cyc();
      logic [8:0] c;
      int         s;
      s = int'($urandom_range(0, 4));
      c = (s == 4) ? 9'h01C : keytab[s];
      cyc(($urandom_range(0, 2) == 0), c, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
   endtask

   task automatic reset_pulse(input int n);
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < n; k++) rand_cyc();
      rst = 1'b1;
   endtask

   // Monitor: compares state every cycle and scoreboard-pops on each accepted head.
   always @(negedge clk) begin
      ev_t e;
      chk("evt_valid", int'(evt_valid), (mdl_cnt > 0) ? 1 : 0);
      chk("choose", int'(choose), mdl_choose);
      chk("overflow", int'(overflow), mdl_ovf);
      if (!evt_valid) begin
         chk("idle_index", int'(evt_index), 0);
         chk("idle_long", int'(evt_long), 0);
      end
      if (rst && evt_valid && evt_ready) begin
         if (scb.size() == 0) begin
            chk("unexpected_event", int'(evt_index), -1);
         end else begin
            e = scb.pop_front();
            chk("evt_index", int'(evt_index), e.idx);
            chk("evt_long", int'(evt_long), e.lng);
         end
      end
   end

   initial begin
      // Reset sanity with traffic during reset
      model_reset();
      for (int k = 0; k < 6; k++) rand_cyc();
      rst = 1'b1;
      idle(3, 1'b1);

      // Short press of 0x072, hold the event one cycle before accepting
      cyc(1'b1, 9'h072, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b0);
      cyc(1'b1, 9'h072, 1'b0, 1'b0, 1'b0);
      idle(1, 1'b0);
      idle(3, 1'b1);

      // Long press with typematic repeats: break at p+9 is long, p+8 is short
      for (int brk = 9; brk >= 8; brk--) begin
         cyc(1'b1, 9'h069, 1'b1, 1'b1, 1'b0);
         for (int k = 1; k <= brk; k++) begin
            if (k == brk)      cyc(1'b1, 9'h069, 1'b0, 1'b1, 1'b0);
            else if (k % 2 == 0) cyc(1'b1, 9'h069, 1'b1, 1'b1, 1'b0);
            else               idle(1, 1'b1);
         end
         idle(3, 1'b1);
      end

      // Key switch abandons the first key; unknown code is ignored
      cyc(1'b1, 9'h069, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 9'h06B, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 9'h069, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 9'h06B, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 9'h01C, 1'b1, 1'b1, 1'b0);
      cyc(1'b1, 9'h01C, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b1);

      // Overflow: five presses with no consumer, clear, then full push with pop
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 9'h074, 1'b1, 1'b0, 1'b0);
         cyc(1'b1, 9'h074, 1'b0, 1'b0, 1'b0);
      end
      idle(2, 1'b0);
      cyc(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
      idle(1, 1'b0);
      cyc(1'b1, 9'h074, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 9'h074, 1'b0, 1'b1, 1'b0);
      idle(1, 1'b0);
      idle(6, 1'b1);

      // Reset mid-hold discards the tracked press
      cyc(1'b1, 9'h072, 1'b1, 1'b1, 1'b0);
      idle(1, 1'b1);
      reset_pulse(1);
      cyc(1'b1, 9'h072, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b1);

      // Randomized traffic with occasional resets
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 599) == 0) reset_pulse(int'($urandom_range(1, 3)));
         else rand_cyc();
      end

      idle(10, 1'b1);
      chk("scb_drained", scb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/key_choice_queue.md
# key_choice_queue

Parametrised key-selection front end that sits between the PS/2 keyboard decoder and the game/dealer control logic. It matches decoded key events against `N_KEYS` programmable scan codes, keeps a latched "current choice", and measures how long each selected key was held. Each completed press (make followed by break) is queued in a small FIFO as a short or long event, so consumers never miss a selection. It supersedes the fixed two-key choose register.

## Interface
- `N_KEYS`, 4: number of recognised keys, 1..15.
- `KEY_CODES`, {9'h074, 9'h06B, 9'h072, 9'h069}: entry i at bits [9i+8:9i], so entry0=0x069 and entry1=0x072.
- `DEPTH`, 4: event FIFO depth, a power of two ≥ 2.
- `HOLD_CYCLES`, 50_000_000: hold length that classifies a press as long.
- Derived: `IW` = $clog2(N_KEYS+1); `CW` = $clog2(HOLD_CYCLES+1).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `key_valid` in 1: one-cycle strobe from the decoder.
- `key_code` in 9: the decoder's last_change code.
- `key_pressed` in 1: key_down[key_code], sampled with `key_valid`. 1 = make, 0 = break.
- `choose` out IW: last selected key as index+1; 0 = none yet.
- `evt_valid` out 1: FIFO non-empty.
- `evt_ready` in 1: consumer accepts the head event.
- `evt_index` out IW: index+1 of the head event.
- `evt_long` out 1: head event was a long press.
- `overflow` out 1: sticky flag, set when an event is dropped.
- `clr_overflow` in 1: clears `overflow`.

## Operation
- Match rule: a code matches entry i when `key_code == KEY_CODES[i]`. If entries are duplicated, the lowest index wins. Non-matching codes are ignored entirely.
- Make of match i (`key_valid & key_pressed`):
  - `choose` <= i+1.
  - Tracker becomes active with `trk_idx` = i and `cnt` <= 0.
  - If the tracker already held a different key, that key is abandoned and no event is produced for it.
  - A repeated make of the already-tracked key (typematic) is ignored: `cnt` is not reset and `choose` is unchanged.
- While the tracker is active, `cnt` increments every cycle and saturates at HOLD_CYCLES.
- Break of a code equal to `KEY_CODES[trk_idx]` while active:
  - Push {trk_idx+1, long = (cnt == HOLD_CYCLES)}.
  - The tracker goes idle.
- A break of an untracked key produces nothing.
- FIFO behaviour:
  - Show-ahead: `evt_index` and `evt_long` reflect the head whenever `evt_valid` = 1.
  - Pop when `evt_valid & evt_ready`.
  - Push and pop in the same cycle are both honoured, including when full.
  - A push while full with no pop drops the new event and sets `overflow`. Stored entries are untouched.
- `overflow` clears on `clr_overflow`. If a set condition and `clr_overflow` occur in the same cycle, set wins.
- Pointers are log2(DEPTH) bits plus a wrap bit; they wrap naturally.
- `evt_index` and `evt_long` are don't-care when `evt_valid` = 0. The implementation drives them to 0.

## Timing
- Reset values (asynchronous on `rst` low): `choose`=0, `evt_valid`=0, `evt_index`=0, `evt_long`=0, `overflow`=0. The tracker is idle, `cnt`=0, and the FIFO is empty.
- Reset asserted mid-hold or with the FIFO non-empty discards everything. No event is produced on release.
- `choose` updates on the clock edge ending the make-strobe cycle, i.e. 1-cycle latency.
- Make strobe at cycle p, break strobe at cycle r:
  - `cnt` at r equals min(r−p−1, HOLD_CYCLES).
  - The event is long iff r ≥ p+1+HOLD_CYCLES.
- Push latency is 1 cycle: a break at r with the FIFO empty gives `evt_valid`=1 at r+1.
- Pop takes effect at the edge. The next head, or `evt_valid`=0, appears the following cycle.
- Handshake rules:
  - `evt_ready` may be held high permanently.
  - `evt_valid` does not depend combinationally on `evt_ready`.
- `key_valid` strobes may arrive on consecutive cycles. Each one is processed independently in its own cycle.

## Test plan
- Setup for all scenarios: HOLD_CYCLES=8, DEPTH=4.
- Reset sanity: hold `rst`=0, drive random strobes, release reset → all outputs 0, no events.
- Short press: make 0x072 at p, break at p+3 → `choose`=2 at p+1; at p+4 `evt_valid`=1, `evt_index`=2, `evt_long`=0; assert `evt_ready` → `evt_valid`=0 the next cycle.
- Long press with typematic: make 0x069 at p, repeat make every 2 cycles, break at p+9 → exactly one event {1, long=1}; break at p+8 in a rerun → long=0.
- Key switch and ignore: make 0x069, make 0x06B, break 0x069, break 0x06B, then make/break 0x01C → `choose`=3; single event {3, 0}; 0x01C produces no change.
- Overflow: 5 short presses of 0x074 with `evt_ready`=0 → 4 events {4,0}, `overflow`=1; pulse `clr_overflow` → 0. A 5th push coinciding with a pop → no overflow, count stays 4.
- Reset mid-hold: make 0x072, assert `rst` low for 1 cycle, then break 0x072 → `choose`=0, no event.
